// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns the select of a shared 4:1 mux, with a per-tenure hold cap.
// Define ARB_FIXED_PRI_EN to switch to fixed priority (req[0] highest); default is round-robin.
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic             done,
    output logic [3:0]       grant,
    output logic [1:0]       sel,
    output logic             gnt_vld,
    output logic [CNT_W-1:0] hold_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state_q;
    logic [3:0]       grant_q;
    logic [1:0]       sel_q;
    logic             gnt_vld_q;
    logic [CNT_W-1:0] hold_cnt_q;

    logic [1:0]       search_base;
    logic             win_found;
    logic [1:0]       win_idx;
    logic [1:0]       cand_idx;
    logic [3:0]       win_onehot;
    logic             release_now;

`ifdef ARB_FIXED_PRI_EN
    // Base of 3 makes the search begin at source 0 every time.
    assign search_base = 2'd3;
`else
    logic [1:0] last_ptr_q;

    // In GRANT the owner is the base, so the owner is considered last.
    assign search_base = (state_q == GRANT) ? sel_q : last_ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_ptr_q <= 2'd3;
        end else if (release_now) begin
            last_ptr_q <= sel_q;
        end
    end
`endif

    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        cand_idx  = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand_idx = search_base + 2'(k + 1);
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
            assign win_onehot[gi] = (win_idx == 2'(gi));
        end
    endgenerate

    assign release_now = (state_q == GRANT) &&
                         (!req[sel_q] || done || (hold_cnt_q == HOLD_LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= 4'b0000;
            sel_q      <= 2'b00;
            gnt_vld_q  <= 1'b0;
            hold_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            if (win_found) begin
                state_q    <= GRANT;
                grant_q    <= win_onehot;
                sel_q      <= win_idx;
                gnt_vld_q  <= 1'b1;
                hold_cnt_q <= '0;
            end
        end else if (!release_now) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
        end else if (win_found) begin
            // Back-to-back handover: no idle bubble between tenures.
            grant_q    <= win_onehot;
            sel_q      <= win_idx;
            hold_cnt_q <= '0;
        end else begin
            // sel keeps the last owner so the mux output stays stable while idle.
            state_q    <= IDLE;
            grant_q    <= 4'b0000;
            gnt_vld_q  <= 1'b0;
            hold_cnt_q <= '0;
        end
    end

    assign grant    = grant_q;
    assign sel      = sel_q;
    assign gnt_vld  = gnt_vld_q;
    assign hold_cnt = hold_cnt_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed steps followed by random traffic,
// every cycle compared against a tenure-level reference model.
module tb_mux4_rr_arbiter;

    localparam int MAX_HOLD = 8;
    localparam int CNT_W    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req;
    logic             done;
    logic [3:0]       grant;
    logic [1:0]       sel;
    logic             gnt_vld;
    logic [CNT_W-1:0] hold_cnt;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    // Reference model: owner index (-1 when idle), mux select, tenure length, last owner.
    int m_owner = -1;
    int m_sel   = 0;
    int m_cnt   = 0;
    int m_last  = 3;

    mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .done     (done),
        .grant    (grant),
        .sel      (sel),
        .gnt_vld  (gnt_vld),
        .hold_cnt (hold_cnt)
    );

    always #5 clk = ~clk;

    function automatic int pick(input int start, input logic [3:0] r);
        int s;
        s = start;
`ifdef ARB_FIXED_PRI_EN
        s = 0;
`endif
        for (int k = 0; k < 4; k++) begin
            if (r[(s + k) % 4]) return (s + k) % 4;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle, obs, exp);
        end
    endtask

    task automatic model_edge();
        int w;
        if (rst) begin
            m_owner = -1;
            m_sel   = 0;
            m_cnt   = 0;
            m_last  = 3;
        end else if (m_owner < 0) begin
            w = pick(m_last + 1, req);
            if (w >= 0) begin
                m_owner = w;
                m_sel   = w;
                m_cnt   = 0;
            end
        end else if (req[m_owner] && !done && m_cnt != MAX_HOLD - 1) begin
            m_cnt++;
        end else begin
            m_last = m_owner;
            w = pick(m_owner + 1, req);
            if (w >= 0) begin
                m_owner = w;
                m_sel   = w;
            end else begin
                m_owner = -1;
            end
            m_cnt = 0;
        end
    endtask

    task automatic tick();
        logic [3:0] exp_grant;
        @(posedge clk);
        model_edge();
        #1;
        cycle++;
        exp_grant = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        check("grant",    32'(grant),    32'(exp_grant));
        check("sel",      32'(sel),      32'(m_sel));
        check("gnt_vld",  32'(gnt_vld),  32'(m_owner >= 0));
        check("hold_cnt", 32'(hold_cnt), 32'(m_cnt));
        $display("cyc=%0d rst=%0b req=%b done=%0b -> grant=%b sel=%0d vld=%0b hold=%0d",
                 cycle, rst, req, done, grant, sel, gnt_vld, hold_cnt);
    endtask

    initial begin
        // T1: reset with all requests asserted
        rst = 1'b1; req = 4'b1111; done = 1'b0;
        tick();
        tick();
        check("t1_grant",    32'(grant),    32'h0);
        check("t1_sel",      32'(sel),      32'h0);
        check("t1_vld",      32'(gnt_vld),  32'h0);
        check("t1_hold_cnt", 32'(hold_cnt), 32'h0);

        // T2: single request from idle, then drop
        rst = 1'b0; req = 4'b0000;
        tick();
        req = 4'b0100;
        tick();
        check("t2_grant", 32'(grant), 32'h4);
        check("t2_sel",   32'(sel),   32'h2);
        req = 4'b0000;
        tick();
        check("t2_idle_grant", 32'(grant), 32'h0);
        check("t2_idle_sel",   32'(sel),   32'h2);
        tick();

        // T3: rotation with done every second cycle
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 12; i++) begin
            done = (i % 2 == 1);
            tick();
        end
        done = 1'b0;

        // T4: two sources, cap enforced
        req = 4'b0000; tick(); tick();
        req = 4'b0011;
        for (int i = 0; i < 28; i++) tick();

        // T5: sole requester re-granted after the cap
        req = 4'b1000;
        for (int i = 0; i < 22; i++) begin
            tick();
            check("t5_vld", 32'(gnt_vld), 32'h1);
        end

        // T6: reset in the middle of a tenure
        req = 4'b0000; tick(); tick();
        req = 4'b0001;
        for (int i = 0; i < 20 && m_cnt != 5; i++) tick();
        check("t6_reach_hold5", 32'(m_cnt), 32'd5);
        rst = 1'b1;
        tick();
        check("t6_grant",    32'(grant),    32'h0);
        check("t6_sel",      32'(sel),      32'h0);
        check("t6_vld",      32'(gnt_vld),  32'h0);
        check("t6_hold_cnt", 32'(hold_cnt), 32'h0);
        rst = 1'b0;

        // Random traffic with occasional resets
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            done = ($urandom_range(0, 4) == 0);
            rst  = ($urandom_range(0, 79) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
